// File: rtl/cm0_acg_ctrl.sv
// -----------------------------------------------------------------------------
// cm0_acg_ctrl
//
// Clock-gate enable controller for one gated clock domain. Runs on the
// free-running HCLK and drives a registered, glitch-free enable into the
// domain's integrated clock-gate cell. It provides:
//   - a SLEEPREQ / SLEEPACK handshake,
//   - an idle-hysteresis count of IDLE_CYC cycles before gating,
//   - a fixed WAKE_CYC delay after re-enabling the clock before SLEEPACK drops.
//
// Optional feature macro: CM0_ACG_CTRL_FORCE_EN
//   defined   -> CLKFORCE port exists; 1 forces the clock on.
//   undefined -> no CLKFORCE port; behaves as if CLKFORCE = 0.
//
// Parameters:
//   IDLE_CYC  idle cycles before gating        (1 .. 2**CNTW)
//   WAKE_CYC  cycles from clock-on to ack drop (1 .. 2**CNTW)
//   CNTW      counter width
//
// Ports:
//   HCLK      in   free-running clock (never gated here)
//   HRESETn   in   asynchronous active-low reset
//   SLEEPREQ  in   level request to stop the domain clock
//   BUSY      in   domain activity; blocks or aborts gating
//   WAKEUP    in   wake event (level or pulse)
//   CLKFORCE  in   force clock on (only with CM0_ACG_CTRL_FORCE_EN)
//   GATE_EN   out  registered enable to the clock gate; 1 = clock runs
//   SLEEPACK  out  registered; 1 = clock stopped or not yet safely restarted
//   CLKSTAT   out  registered state: 00 RUN, 01 IDLE, 10 GATED, 11 WAKE
// -----------------------------------------------------------------------------
module cm0_acg_ctrl #(
    parameter int IDLE_CYC = 8,
    parameter int WAKE_CYC = 2,
    parameter int CNTW     = 4
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       SLEEPREQ,
    input  logic       BUSY,
    input  logic       WAKEUP,
`ifdef CM0_ACG_CTRL_FORCE_EN
    input  logic       CLKFORCE,
`endif
    output logic       GATE_EN,
    output logic       SLEEPACK,
    output logic [1:0] CLKSTAT
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_IDLE  = 2'b01,
        ST_GATED = 2'b10,
        ST_WAKE  = 2'b11
    } state_t;

    localparam logic [CNTW-1:0] IDLE_LOAD = CNTW'(IDLE_CYC - 1);
    localparam logic [CNTW-1:0] WAKE_LOAD = CNTW'(WAKE_CYC - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNTW-1:0]   r_cnt;
    logic [CNTW-1:0]   w_cnt_nxt;
    logic              r_gate_en;
    logic              r_sleepack;
    logic              w_gate_en_nxt;
    logic              w_sleepack_nxt;
    logic              w_force;
    logic              w_abort;
    logic              w_wake_evt;

`ifdef CM0_ACG_CTRL_FORCE_EN
    assign w_force = CLKFORCE;
`else
    // Constant zero: all force terms fold away in synthesis.
    assign w_force = 1'b0;
`endif

    // Anything that cancels or blocks an idle pass.
    assign w_abort    = ~SLEEPREQ | BUSY | WAKEUP | w_force;
    // Events that end a gated period; BUSY alone does not restart the clock.
    assign w_wake_evt = WAKEUP | ~SLEEPREQ | w_force;

    // -------------------------------------------------------------------------
    // State, counter and output registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    // NOTE: asynchronous reset forces RUN with the clock enabled, so a domain
    // caught in GATED restarts at once without a WAKE delay.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state    <= ST_RUN;
            r_cnt      <= '0;
            r_gate_en  <= 1'b1;
            r_sleepack <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_gate_en  <= w_gate_en_nxt;
            r_sleepack <= w_sleepack_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and counter logic
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first so no latch is
    // inferred on any path.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ST_RUN: begin
                if (!w_abort) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = IDLE_LOAD;
                end
            end
            ST_IDLE: begin
                // Abort wins over gating even with the counter at zero.
                if (w_abort) begin
                    w_state_nxt = ST_RUN;
                end else if (r_cnt == '0) begin
                    w_state_nxt = ST_GATED;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            ST_GATED: begin
                if (w_wake_evt) begin
                    w_state_nxt = ST_WAKE;
                    w_cnt_nxt   = WAKE_LOAD;
                end
            end
            ST_WAKE: begin
                // Inputs are ignored so the restart delay always completes.
                if (r_cnt == '0) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode from next state (registered above, so no input reaches
    // an output combinationally and GATE_EN cannot glitch).
    // -------------------------------------------------------------------------
    always_comb begin
        w_gate_en_nxt  = (w_state_nxt != ST_GATED);
        w_sleepack_nxt = (w_state_nxt == ST_GATED) || (w_state_nxt == ST_WAKE);
    end

    assign GATE_EN  = r_gate_en;
    assign SLEEPACK = r_sleepack;
    assign CLKSTAT  = r_state;

endmodule

// File: tb/tb_cm0_acg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cm0_acg_ctrl
//
// Directed, table-driven bench for cm0_acg_ctrl. One instance uses the default
// IDLE_CYC=8 / WAKE_CYC=2; a second instance uses IDLE_CYC=1 for the counter
// boundary. Each table row gives the inputs sampled at one HCLK edge and the
// outputs expected just after that edge.
// -----------------------------------------------------------------------------
module tb_cm0_acg_ctrl;

    logic       HCLK;
    logic       HRESETn;

    logic       sleepreq, busy, wakeup;
    logic       gate_en, sleepack;
    logic [1:0] clkstat;

    logic       sleepreq1, busy1, wakeup1;
    logic       gate_en1, sleepack1;
    logic [1:0] clkstat1;

`ifdef CM0_ACG_CTRL_FORCE_EN
    logic       clkforce;
    logic       clkforce1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [1:0] S_RUN   = 2'b00;
    localparam logic [1:0] S_IDLE  = 2'b01;
    localparam logic [1:0] S_GATED = 2'b10;
    localparam logic [1:0] S_WAKE  = 2'b11;

    typedef struct {
        logic       s;
        logic       b;
        logic       w;
        logic       g;
        logic       a;
        logic [1:0] st;
    } vec_t;

    vec_t vecs[$];

    cm0_acg_ctrl #(.IDLE_CYC(8), .WAKE_CYC(2), .CNTW(4)) u_dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .SLEEPREQ (sleepreq),
        .BUSY     (busy),
        .WAKEUP   (wakeup),
`ifdef CM0_ACG_CTRL_FORCE_EN
        .CLKFORCE (clkforce),
`endif
        .GATE_EN  (gate_en),
        .SLEEPACK (sleepack),
        .CLKSTAT  (clkstat)
    );

    cm0_acg_ctrl #(.IDLE_CYC(1), .WAKE_CYC(2), .CNTW(4)) u_dut1 (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .SLEEPREQ (sleepreq1),
        .BUSY     (busy1),
        .WAKEUP   (wakeup1),
`ifdef CM0_ACG_CTRL_FORCE_EN
        .CLKFORCE (clkforce1),
`endif
        .GATE_EN  (gate_en1),
        .SLEEPACK (sleepack1),
        .CLKSTAT  (clkstat1)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    // Watchdog: the bench waits only on clock edges, but never let it hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_main(input string tag, input logic g, input logic a, input logic [1:0] st);
        check({tag, " GATE_EN"},  {1'b0, gate_en},  {1'b0, g});
        check({tag, " SLEEPACK"}, {1'b0, sleepack}, {1'b0, a});
        check({tag, " CLKSTAT"},  clkstat,          st);
    endtask

    task automatic check_dut1(input string tag, input logic g, input logic a, input logic [1:0] st);
        check({tag, " GATE_EN"},  {1'b0, gate_en1},  {1'b0, g});
        check({tag, " SLEEPACK"}, {1'b0, sleepack1}, {1'b0, a});
        check({tag, " CLKSTAT"},  clkstat1,          st);
    endtask

    task automatic add(input logic s, input logic b, input logic w,
                       input logic g, input logic a, input logic [1:0] st);
        vec_t v;
        v.s = s; v.b = b; v.w = w; v.g = g; v.a = a; v.st = st;
        vecs.push_back(v);
    endtask

    // Advance one HCLK edge and settle just after it.
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        HRESETn   = 1'b0;
        sleepreq  = 1'b0; busy  = 1'b0; wakeup  = 1'b0;
        sleepreq1 = 1'b0; busy1 = 1'b0; wakeup1 = 1'b0;
`ifdef CM0_ACG_CTRL_FORCE_EN
        clkforce  = 1'b0;
        clkforce1 = 1'b0;
`endif

        // ---------------------------------------------------------------
        // Vector table for the IDLE_CYC=8 / WAKE_CYC=2 instance.
        // Row k = HCLK edge k after reset release.
        // ---------------------------------------------------------------
        // Basic gating: SLEEPREQ from edge 0, gate at edge 8.
        for (int i = 0; i < 8; i++) add(1, 0, 0, 1, 0, S_IDLE);   // 0..7
        add(1, 0, 0, 0, 1, S_GATED);                              // 8
        // Wake one cycle later (minimum gated time), SLEEPREQ still high.
        add(1, 0, 1, 1, 1, S_WAKE);                               // 9  (M)
        add(1, 0, 0, 1, 1, S_WAKE);                               // 10 (M+1)
        add(1, 0, 0, 1, 0, S_RUN);                                // 11 (M+2)
        add(0, 0, 0, 1, 0, S_RUN);                                // 12
        // Abort in IDLE: new pass from edge 13, BUSY at its edge 5.
        for (int i = 0; i < 5; i++) add(1, 0, 0, 1, 0, S_IDLE);   // 13..17
        add(1, 1, 0, 1, 0, S_RUN);                                // 18
        for (int i = 0; i < 8; i++) add(1, 0, 0, 1, 0, S_IDLE);   // 19..26
        add(1, 0, 0, 0, 1, S_GATED);                              // 27 (= 13+14)
        // BUSY ignored in GATED; SLEEPREQ drop wakes; WAKE ignores inputs.
        add(1, 1, 0, 0, 1, S_GATED);                              // 28
        add(0, 0, 0, 1, 1, S_WAKE);                               // 29
        add(1, 0, 0, 1, 1, S_WAKE);                               // 30
        add(1, 0, 0, 1, 0, S_RUN);                                // 31
        // No direct WAKE->IDLE: SLEEPREQ still high re-enters from RUN.
        add(1, 0, 0, 1, 0, S_IDLE);                               // 32
        add(1, 0, 1, 1, 0, S_RUN);                                // 33 WAKEUP abort
        add(0, 0, 0, 1, 0, S_RUN);                                // 34
        // Abort beats gating with the counter at zero.
        for (int i = 0; i < 8; i++) add(1, 0, 0, 1, 0, S_IDLE);   // 35..42
        add(1, 1, 0, 1, 0, S_RUN);                                // 43
        add(0, 0, 0, 1, 0, S_RUN);                                // 44

        // ---------------------------------------------------------------
        // Reset state (checked while reset is asserted).
        // ---------------------------------------------------------------
        tick();
        tick();
        check_main("reset", 1'b1, 1'b0, S_RUN);
        check_dut1("reset1", 1'b1, 1'b0, S_RUN);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);

        // ---------------------------------------------------------------
        // Apply the table.
        // ---------------------------------------------------------------
        foreach (vecs[k]) begin
            sleepreq = vecs[k].s;
            busy     = vecs[k].b;
            wakeup   = vecs[k].w;
            tick();
            check_main($sformatf("vec%0d", k), vecs[k].g, vecs[k].a, vecs[k].st);
        end
        sleepreq = 1'b0; busy = 1'b0; wakeup = 1'b0;

        // ---------------------------------------------------------------
        // Counter boundary, IDLE_CYC=1: gate one edge after the request.
        // ---------------------------------------------------------------
        sleepreq1 = 1'b1;
        tick(); check_dut1("b1 e0", 1'b1, 1'b0, S_IDLE);
        tick(); check_dut1("b1 e1", 1'b0, 1'b1, S_GATED);
        wakeup1 = 1'b1;
        tick(); check_dut1("b1 wake", 1'b1, 1'b1, S_WAKE);
        wakeup1 = 1'b0; sleepreq1 = 1'b0;
        tick(); check_dut1("b1 wake+1", 1'b1, 1'b1, S_WAKE);
        tick(); check_dut1("b1 wake+2", 1'b1, 1'b0, S_RUN);
        // WAKEUP at edge 1 of a new pass aborts before gating.
        sleepreq1 = 1'b1;
        tick(); check_dut1("b1 abort e0", 1'b1, 1'b0, S_IDLE);
        wakeup1 = 1'b1;
        tick(); check_dut1("b1 abort e1", 1'b1, 1'b0, S_RUN);
        sleepreq1 = 1'b0; wakeup1 = 1'b0;
        tick(); check_dut1("b1 abort e2", 1'b1, 1'b0, S_RUN);

        // ---------------------------------------------------------------
        // Asynchronous reset while GATED.
        // ---------------------------------------------------------------
        sleepreq = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        check_main("pre-reset gated", 1'b0, 1'b1, S_GATED);
        #2;
        HRESETn = 1'b0;
        #1;
        check_main("async reset", 1'b1, 1'b0, S_RUN);
        sleepreq = 1'b0;
        @(negedge HCLK);
        HRESETn = 1'b1;
        tick();
        check_main("post reset", 1'b1, 1'b0, S_RUN);

`ifdef CM0_ACG_CTRL_FORCE_EN
        // ---------------------------------------------------------------
        // CLKFORCE: wakes from GATED and blocks any new idle pass.
        // ---------------------------------------------------------------
        sleepreq = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        check_main("force pre gated", 1'b0, 1'b1, S_GATED);
        clkforce = 1'b1;
        tick(); check_main("force wake", 1'b1, 1'b1, S_WAKE);
        tick(); check_main("force wake+1", 1'b1, 1'b1, S_WAKE);
        tick(); check_main("force run", 1'b1, 1'b0, S_RUN);
        for (int i = 0; i < 20; i++) begin
            tick();
            check_main($sformatf("force hold%0d", i), 1'b1, 1'b0, S_RUN);
        end
        clkforce = 1'b0;
        sleepreq = 1'b0;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
